// File: rtl/store_aligner_pkg.sv
// Shared definitions for the store aligner: size codes, FSM states and lane masks.
// Helper functions derive lane masks and boundary crossing from the size code and byte offset.
package store_aligner_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_mask = MASK_BYTE;
            SZ_HALF: size_mask = MASK_HALF;
            SZ_WORD: size_mask = MASK_WORD;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    // A store needs a second beat when its last byte lands in the next word.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        crosses = (({1'b0, off} + size_bytes(sz)) > 3'd4);
    endfunction

endpackage

// File: rtl/store_aligner_lane_shifter.sv
// Places a right-justified store value onto the byte lanes of one write beat.
// Beat 0 carries the low bytes shifted up by the offset; beat 1 carries the spill-over.
module store_lane_shifter
    import store_aligner_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        beat_sel,
    output logic [31:0] wdata,
    output logic [3:0]  be
);

    logic [3:0]  mask;
    logic [31:0] masked;
    logic [2:0]  lane_shift;

    always_comb begin
        mask       = size_mask(size);
        masked     = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        lane_shift = 3'd0;
        wdata      = 32'd0;
        be         = 4'd0;
        if (!beat_sel) begin
            lane_shift = {1'b0, offset};
            wdata      = masked << {lane_shift, 3'b000};
            be         = mask << lane_shift;
        end else begin
            // A zero offset gives a full-width shift, which empties the second beat.
            lane_shift = 3'd4 - {1'b0, offset};
            wdata      = masked >> {lane_shift, 3'b000};
            be         = mask >> lane_shift;
        end
    end

endmodule

// File: rtl/store_aligner.sv
// Converts a byte/halfword/word store into one or two word-aligned memory write beats.
// All outputs are decoded from registered state and the request latched at acceptance.
module store_aligner
    import store_aligner_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [1:0]  size,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        done,
    output logic        err
);

    state_t      state, next_state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic        accept;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] base_addr;

    assign accept    = in_valid && in_ready;
    assign base_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= 32'd0;
            data_q <= 32'd0;
            size_q <= SZ_BYTE;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q <= addr;
                data_q <= data_in;
                size_q <= size;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept)
                    next_state = (size == SZ_RSVD) ? DONE : BEAT0;
            end
            BEAT0: begin
                if (mem_ack)
                    next_state = crosses(addr_q[1:0], size_q) ? BEAT1 : DONE;
            end
            BEAT1: begin
                if (mem_ack)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    store_lane_shifter u_shifter (
        .data     (data_q),
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .beat_sel (state == BEAT1),
        .wdata    (lane_wdata),
        .be       (lane_be)
    );

    // Beat fields come only from latched registers, so they stay stable while ack is low.
    always_comb begin
        in_ready  = (state == IDLE);
        mem_req   = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = base_addr;
                mem_wdata = lane_wdata;
                mem_be    = lane_be;
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = base_addr + 32'd4;
                mem_wdata = lane_wdata;
                mem_be    = lane_be;
            end
            DONE: begin
                done = 1'b1;
                err  = (size_q == SZ_RSVD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_aligner.sv
// Bench for store_aligner: directed and random stores checked against a byte-level model.
// The model spreads each stored byte to its own address and groups bytes by word.
module tb_store_aligner;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [1:0]  size;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    int          n_beats;
    logic        exp_err;
    logic [31:0] exp_addr  [2];
    logic [31:0] exp_wdata [2];
    logic [3:0]  exp_be    [2];

    store_aligner dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr      (addr),
        .data_in   (data_in),
        .size      (size),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Each stored byte k goes to address addr+k; bytes outside the first word form beat 1.
    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int          nbytes;
        int          beat;
        logic [31:0] ba;
        n_beats = 0;
        exp_err = (sz == 2'd3);
        for (int b = 0; b < 2; b++) begin
            exp_addr[b]  = 32'd0;
            exp_wdata[b] = 32'd0;
            exp_be[b]    = 4'd0;
        end
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        for (int k = 0; k < nbytes; k++) begin
            ba   = a + 32'(k);
            beat = (ba[31:2] == a[31:2]) ? 0 : 1;
            exp_addr[beat]                    = {ba[31:2], 2'b00};
            exp_wdata[beat][8*ba[1:0] +: 8]   = d[8*k +: 8];
            exp_be[beat][ba[1:0]]             = 1'b1;
            if (beat + 1 > n_beats) n_beats = beat + 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        check_output("ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        addr     = a;
        data_in  = d;
        size     = sz;
        step();
        in_valid = 1'b0;
        addr     = $urandom;
        data_in  = $urandom;
        size     = 2'($urandom_range(0, 3));
    endtask

    // Runs one store with the given ack delay per beat and checks every cycle until idle.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input int delay);
        model_store(a, d, sz);
        apply_stimulus(a, d, sz);
        for (int b = 0; b < n_beats; b++) begin
            for (int i = 0; i <= delay; i++) begin
                check_output("beat_req",   32'(mem_req),   32'd1);
                check_output("beat_addr",  mem_addr,       exp_addr[b]);
                check_output("beat_wdata", mem_wdata,      exp_wdata[b]);
                check_output("beat_be",    32'(mem_be),    32'(exp_be[b]));
                check_output("beat_done",  32'(done),      32'd0);
                check_output("beat_ready", 32'(in_ready),  32'd0);
                mem_ack = (i == delay);
                step();
                mem_ack = 1'b0;
            end
        end
        check_output("done_pulse", 32'(done),     32'd1);
        check_output("done_err",   32'(err),      32'(exp_err));
        check_output("done_noreq", 32'(mem_req),  32'd0);
        check_output("done_addr",  mem_addr,      32'd0);
        check_output("done_ready", 32'(in_ready), 32'd0);
        step();
        check_output("idle_done",  32'(done),     32'd0);
        check_output("idle_err",   32'(err),      32'd0);
        check_output("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        addr     = 32'd0;
        data_in  = 32'd0;
        size     = 2'd0;
        step();
        // A request offered during reset must not be taken.
        in_valid = 1'b1;
        addr     = 32'h0000_1000;
        data_in  = 32'hFFFF_FFFF;
        size     = 2'd2;
        step();
        check_output("rst_ready", 32'(in_ready),  32'd1);
        check_output("rst_req",   32'(mem_req),   32'd0);
        check_output("rst_done",  32'(done),      32'd0);
        check_output("rst_err",   32'(err),       32'd0);
        check_output("rst_addr",  mem_addr,       32'd0);
        check_output("rst_wdata", mem_wdata,      32'd0);
        check_output("rst_be",    32'(mem_be),    32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        check_output("post_rst_req", 32'(mem_req), 32'd0);

        // Ack while idle is ignored.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_output("idle_ack_req",  32'(mem_req), 32'd0);
        check_output("idle_ack_done", 32'(done),    32'd0);

        run_store(32'h0000_1002, 32'h0000_00A5, 2'd0, 0);
        run_store(32'h0000_2003, 32'h1234_BEEF, 2'd1, 0);
        run_store(32'h0000_3001, 32'h1122_3344, 2'd2, 3);
        run_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 2'd2, 0);
        run_store(32'h0000_4000, 32'hDEAD_BEEF, 2'd3, 0);
        run_store(32'h0000_5000, 32'h89AB_CDEF, 2'd2, 1);

        // Abandon a crossing halfword while its second beat is pending.
        model_store(32'h0000_2003, 32'h1234_BEEF, 2'd1);
        apply_stimulus(32'h0000_2003, 32'h1234_BEEF, 2'd1);
        check_output("abort_b0_be", 32'(mem_be), 32'(exp_be[0]));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_output("abort_b1_req",  32'(mem_req), 32'd1);
        check_output("abort_b1_addr", mem_addr,     exp_addr[1]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("abort_req",   32'(mem_req),  32'd0);
        check_output("abort_done",  32'(done),     32'd0);
        check_output("abort_ready", 32'(in_ready), 32'd1);
        step();
        check_output("abort_done2", 32'(done),     32'd0);
        run_store(32'h0000_6001, 32'h0000_7788, 2'd1, 0);

        for (int n = 0; n < 40; n++) begin
            run_store($urandom, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
